axi_rd_arb: RTL and testbench

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb_pkg.sv | 34 +++
 rtl/arb_grant.sv | 20 ++
 rtl/axi_rd_arb.sv | 140 ++++++++++++++
 tb/tb_axi_rd_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// Bus widths default to the YSYX_23060251_AXI_ADDR / YSYX_23060251_AXI_DATA defines.
`ifndef YSYX_23060251_AXI_ADDR
`define YSYX_23060251_AXI_ADDR 32
`endif
`ifndef YSYX_23060251_AXI_DATA
`define YSYX_23060251_AXI_DATA 32
`endif

package axi_rd_arb_pkg;

    localparam int unsigned AxiAddrW = `YSYX_23060251_AXI_ADDR;
    localparam int unsigned AxiDataW = `YSYX_23060251_AXI_DATA;
    localparam int unsigned NumReq   = 2;

    // Requester indices; also used as the downstream AR ID.
    localparam logic ReqIfu = 1'b0;
    localparam logic ReqLsu = 1'b1;

    // Every transaction is a single INCR beat.
    localparam logic [7:0] AxiLenSingle = 8'd0;
    localparam logic [1:0] AxiBurstIncr = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    function automatic logic grant_to_idx(input logic [NumReq-1:0] grant);
        return (grant == 2'b10) ? ReqLsu : ReqIfu;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Two-way grant pick: a lone request wins outright, a tie goes to the
// requester named by prio_i.
module arb_grant
    import axi_rd_arb_pkg::*;
(
    input  logic              prio_i,
    input  logic [NumReq-1:0] valid_i,
    output logic [NumReq-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (valid_i[0] && valid_i[1]) begin
            grant_o[prio_i] = 1'b1;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// AXI read arbiter: IFU (bit0) and LSU (bit1) share one single-beat read port.
// Define YSYX_23060251_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
`ifndef YSYX_23060251_AXI_ADDR
`define YSYX_23060251_AXI_ADDR 32
`endif
`ifndef YSYX_23060251_AXI_DATA
`define YSYX_23060251_AXI_DATA 32
`endif

module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = AxiAddrW,
    parameter int unsigned DATA_W = AxiDataW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [1:0]            s_ar_valid_i,
    output logic [1:0]            s_ar_ready_o,
    input  logic [2*ADDR_W-1:0]   s_ar_addr_i,
    input  logic [5:0]            s_ar_size_i,
    output logic [1:0]            s_r_valid_o,
    input  logic [1:0]            s_r_ready_i,
    output logic [DATA_W-1:0]     s_r_data_o,
    output logic [1:0]            s_r_resp_o,

    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    output logic [ADDR_W-1:0]     mst_ar_addr_o,
    output logic [2:0]            mst_ar_size_o,
    output logic [3:0]            mst_ar_id_o,
    output logic [7:0]            mst_ar_len_o,
    output logic [1:0]            mst_ar_burst_o,
    input  logic                  mst_r_valid_i,
    output logic                  mst_r_ready_o,
    input  logic [DATA_W-1:0]     mst_r_data_i,
    input  logic [1:0]            mst_r_resp_i,
    input  logic                  mst_r_last_i
);

    state_e             state_q;
    logic               grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [2:0]         size_q;
    logic               ar_valid_q;

    logic [1:0]         pick;
    logic               pick_idx;
    logic               prio;
    logic               in_idle;
    logic               in_data;
    logic               r_done;

`ifdef YSYX_23060251_ARB_RR_EN
    logic               rr_ptr_q;
    assign prio = rr_ptr_q;
`else
    assign prio = ReqLsu;
`endif

    arb_grant u_arb_grant (
        .prio_i  (prio),
        .valid_i (s_ar_valid_i),
        .grant_o (pick)
    );

    assign pick_idx = grant_to_idx(pick);

    // The accept is combinational, so it must also be masked while reset is held.
    assign in_idle = (state_q == StIdle) && !rst_i;
    assign in_data = (state_q == StData);

    assign s_ar_ready_o = in_idle ? pick : 2'b00;

    assign mst_ar_valid_o = ar_valid_q;
    assign mst_ar_addr_o  = addr_q;
    assign mst_ar_size_o  = size_q;
    assign mst_ar_id_o    = {3'b000, grant_q};
    assign mst_ar_len_o   = AxiLenSingle;
    assign mst_ar_burst_o = AxiBurstIncr;

    assign mst_r_ready_o = in_data && s_r_ready_i[grant_q];
    assign s_r_data_o    = mst_r_data_i;
    assign s_r_resp_o    = mst_r_resp_i;
    assign r_done        = mst_r_valid_i && mst_r_ready_o && mst_r_last_i;

    always_comb begin
        s_r_valid_o = 2'b00;
        if (in_data) begin
            s_r_valid_o[grant_q] = mst_r_valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            grant_q    <= ReqIfu;
            addr_q     <= '0;
            size_q     <= '0;
            ar_valid_q <= 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
            rr_ptr_q   <= ReqIfu;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|s_ar_valid_i) begin
                        grant_q    <= pick_idx;
                        addr_q     <= pick_idx ? s_ar_addr_i[2*ADDR_W-1:ADDR_W]
                                               : s_ar_addr_i[ADDR_W-1:0];
                        size_q     <= pick_idx ? s_ar_size_i[5:3] : s_ar_size_i[2:0];
                        ar_valid_q <= 1'b1;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    if (mst_ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    // Beats without rlast are forwarded but keep the transaction open.
                    if (r_done) begin
                        state_q  <= StIdle;
`ifdef YSYX_23060251_ARB_RR_EN
                        rr_ptr_q <= ~rr_ptr_q;
`endif
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    ar_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Scoreboard bench for axi_rd_arb: stimulus pushes expected AR/R items,
// a negedge monitor pops and compares them on every handshake.
module tb_axi_rd_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      s_ar_valid;
    logic [1:0]      s_ar_ready;
    logic [2*AW-1:0] s_ar_addr;
    logic [5:0]      s_ar_size;
    logic [1:0]      s_r_valid;
    logic [1:0]      s_r_ready;
    logic [DW-1:0]   s_r_data;
    logic [1:0]      s_r_resp;
    logic            mst_ar_valid;
    logic            mst_ar_ready;
    logic [AW-1:0]   mst_ar_addr;
    logic [2:0]      mst_ar_size;
    logic [3:0]      mst_ar_id;
    logic [7:0]      mst_ar_len;
    logic [1:0]      mst_ar_burst;
    logic            mst_r_valid;
    logic            mst_r_ready;
    logic [DW-1:0]   mst_r_data;
    logic [1:0]      mst_r_resp;
    logic            mst_r_last;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [3:0]    id;
    } ar_exp_t;

    typedef struct {
        logic [1:0]    dst;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    ar_exp_t mon_ar;
    r_exp_t  mon_r;

    always #5 clk = ~clk;

    axi_rd_arb #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .s_ar_valid_i   (s_ar_valid),
        .s_ar_ready_o   (s_ar_ready),
        .s_ar_addr_i    (s_ar_addr),
        .s_ar_size_i    (s_ar_size),
        .s_r_valid_o    (s_r_valid),
        .s_r_ready_i    (s_r_ready),
        .s_r_data_o     (s_r_data),
        .s_r_resp_o     (s_r_resp),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .mst_ar_addr_o  (mst_ar_addr),
        .mst_ar_size_o  (mst_ar_size),
        .mst_ar_id_o    (mst_ar_id),
        .mst_ar_len_o   (mst_ar_len),
        .mst_ar_burst_o (mst_ar_burst),
        .mst_r_valid_i  (mst_r_valid),
        .mst_r_ready_o  (mst_r_ready),
        .mst_r_data_i   (mst_r_data),
        .mst_r_resp_i   (mst_r_resp),
        .mst_r_last_i   (mst_r_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every AR or R handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mst_ar_valid && mst_ar_ready) begin
                if (ar_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected: got addr 0x%0h, want no AR", mst_ar_addr);
                end else begin
                    mon_ar = ar_q.pop_front();
                    check("ar_addr", mst_ar_addr, mon_ar.addr);
                    check("ar_size", mst_ar_size, mon_ar.size);
                    check("ar_id", mst_ar_id, mon_ar.id);
                    check("ar_len_burst", {mst_ar_len, mst_ar_burst}, {8'd0, 2'b01});
                end
            end
            if (|(s_r_valid & s_r_ready)) begin
                if (r_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rvalid 0x%0h, want no beat", s_r_valid);
                end else begin
                    mon_r = r_q.pop_front();
                    check("r_dst", s_r_valid, mon_r.dst);
                    check("r_data", s_r_data, mon_r.data);
                    check("r_resp", s_r_resp, mon_r.resp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic request(input logic [1:0] vmask, input logic [1:0] exp_g,
                           input logic [AW-1:0] a_ifu, input logic [AW-1:0] a_lsu,
                           input logic [2:0] z_ifu, input logic [2:0] z_lsu,
                           input logic [DW-1:0] rdata, input logic [1:0] rresp,
                           input string tag);
        int n;
        logic [1:0] got;
        ar_exp_t ea;
        r_exp_t er;
        s_ar_addr  = {a_lsu, a_ifu};
        s_ar_size  = {z_lsu, z_ifu};
        s_ar_valid = s_ar_valid | vmask;
        n = 0;
        @(negedge clk);
        while (s_ar_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = s_ar_ready;
        check({tag, "_grant"}, got, exp_g);
        ea.addr = exp_g[1] ? a_lsu : a_ifu;
        ea.size = exp_g[1] ? z_lsu : z_ifu;
        ea.id   = {3'b000, exp_g[1]};
        ar_q.push_back(ea);
        er.dst  = exp_g;
        er.data = rdata;
        er.resp = rresp;
        r_q.push_back(er);
        @(posedge clk);
        #1;
        s_ar_valid = s_ar_valid & ~got;
    endtask

    task automatic serve_ar(input int ar_wait, input string tag);
        int n;
        logic [AW-1:0] a0;
        n = 0;
        while (!mst_ar_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ar_latency"}, n, 0);
        a0 = mst_ar_addr;
        repeat (ar_wait) begin
            tick();
            check({tag, "_ar_hold"}, {mst_ar_valid, mst_ar_addr}, {1'b1, a0});
        end
        mst_ar_ready = 1'b1;
        tick();
        mst_ar_ready = 1'b0;
    endtask

    task automatic serve_r(input int dst, input logic [DW-1:0] d, input logic [1:0] resp,
                           input int stall, input int beats, input string tag);
        int n;
        logic [1:0] oh;
        oh = (dst == 1) ? 2'b10 : 2'b01;
        for (int b = 0; b < beats; b++) begin
            mst_r_valid = 1'b1;
            mst_r_data  = d + DW'(b);
            mst_r_resp  = resp;
            mst_r_last  = (b == beats - 1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    s_r_ready[dst] = 1'b0;
                    #1;
                    check({tag, "_stall_rready"}, {s_r_valid, mst_r_ready}, {oh, 1'b0});
                    tick();
                end
            end
            s_r_ready = 2'b11;
            n = 0;
            @(negedge clk);
            while (!mst_r_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_r_route"}, {s_r_valid, mst_r_ready}, {oh, 1'b1});
            tick();
        end
        mst_r_valid = 1'b0;
        mst_r_last  = 1'b0;
        #1;
        check({tag, "_back_idle"}, mst_r_ready, 1'b0);
    endtask

    logic [1:0] exp_grants [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        s_ar_valid   = 2'b11;
        s_ar_addr    = '0;
        s_ar_size    = '0;
        s_r_ready    = 2'b11;
        mst_ar_ready = 1'b1;
        mst_r_valid  = 1'b1;
        mst_r_data   = '0;
        mst_r_resp   = '0;
        mst_r_last   = 1'b1;
        #2;
        check("reset_s_ar_ready", s_ar_ready, 2'b00);
        check("reset_mst_ar", {mst_ar_valid, mst_ar_addr, mst_ar_size, mst_ar_id}, '0);
        check("reset_mst_r_ready", mst_r_ready, 1'b0);
        check("reset_s_r_valid", s_r_valid, 2'b00);
        s_ar_valid   = 2'b00;
        mst_ar_ready = 1'b0;
        mst_r_valid  = 1'b0;
        mst_r_last   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // IFU-only fetch, downstream accepts AR after two cycles.
        request(2'b01, 2'b01, 32'h8000_0000, 32'h0, 3'd2, 3'd0, 32'h0000_0413, 2'b00, "ifu");
        serve_ar(2, "ifu");
        serve_r(0, 32'h0000_0413, 2'b00, 0, 1, "ifu");

        // Simultaneous requests, three back to back.
        do_reset();
`ifdef YSYX_23060251_ARB_RR_EN
        exp_grants[0] = 2'b01;
        exp_grants[1] = 2'b10;
        exp_grants[2] = 2'b01;
`else
        exp_grants[0] = 2'b10;
        exp_grants[1] = 2'b10;
        exp_grants[2] = 2'b10;
`endif
        for (int i = 0; i < 3; i++) begin
            request(2'b11, exp_grants[i], 32'h1000_0000 + 32'(i * 4),
                    32'h2000_0000 + 32'(i * 4), 3'd2, 3'd1,
                    32'hA000_0000 + 32'(i), 2'b00, "both");
            serve_ar(i, "both");
            serve_r(exp_grants[i][1] ? 1 : 0, 32'hA000_0000 + 32'(i), 2'b00, 0, 1, "both");
        end
        s_ar_valid = 2'b00;

        // LSU read with R backpressure.
        request(2'b10, 2'b10, 32'h0, 32'h0200_0000, 3'd0, 3'd2, 32'hDEAD_BEEF, 2'b00, "stall");
        serve_ar(0, "stall");
        serve_r(1, 32'hDEAD_BEEF, 2'b00, 3, 1, "stall");

        // SLVERR on LSU is forwarded, next IFU read is normal.
        request(2'b10, 2'b10, 32'h0, 32'h0200_0008, 3'd0, 3'd3, 32'h0000_1234, 2'b10, "slverr");
        serve_ar(1, "slverr");
        serve_r(1, 32'h0000_1234, 2'b10, 0, 1, "slverr");
        request(2'b01, 2'b01, 32'h8000_0004, 32'h0, 3'd2, 3'd0, 32'h0000_0013, 2'b00, "after");
        serve_ar(0, "after");
        serve_r(0, 32'h0000_0013, 2'b00, 0, 1, "after");

        // Non-last beat forwarded, transaction closes on the last one.
        request(2'b01, 2'b01, 32'h8000_0010, 32'h0, 3'd2, 3'd0, 32'h0000_5000, 2'b00, "multi");
        begin
            r_exp_t er;
            er.dst  = 2'b01;
            er.data = 32'h0000_5001;
            er.resp = 2'b00;
            r_q.push_back(er);
        end
        serve_ar(0, "multi");
        serve_r(0, 32'h0000_5000, 2'b00, 0, 2, "multi");

        // IFU pulses a request while busy and drops it: it is lost.
        request(2'b10, 2'b10, 32'h0, 32'h0300_0000, 3'd0, 3'd2, 32'h0000_0077, 2'b00, "drop");
        s_ar_valid[0] = 1'b1;
        #1;
        check("drop_busy_no_ready", s_ar_ready, 2'b00);
        tick();
        s_ar_valid[0] = 1'b0;
        serve_ar(0, "drop");
        serve_r(1, 32'h0000_0077, 2'b00, 0, 1, "drop");
        for (int i = 0; i < 3; i++) begin
            check("drop_no_ar", {mst_ar_valid, s_ar_ready}, 3'b000);
            tick();
        end

        // IFU held while LSU is busy: granted on the first IDLE cycle.
        request(2'b10, 2'b10, 32'h0, 32'h0300_0010, 3'd0, 3'd2, 32'h0000_0088, 2'b00, "wait");
        s_ar_valid[0] = 1'b1;
        s_ar_addr[AW-1:0] = 32'h8000_0020;
        serve_ar(0, "wait");
        serve_r(1, 32'h0000_0088, 2'b00, 0, 1, "wait");
        check("wait_first_idle", s_ar_ready, 2'b01);
        request(2'b01, 2'b01, 32'h8000_0020, 32'h0, 3'd2, 3'd0, 32'h0000_0099, 2'b00, "wait2");
        serve_ar(0, "wait2");
        serve_r(0, 32'h0000_0099, 2'b00, 0, 1, "wait2");

        // Reset in DATA before any R beat.
        request(2'b01, 2'b01, 32'h8000_0100, 32'h0, 3'd2, 3'd0, 32'h0000_0055, 2'b00, "rst");
        serve_ar(0, "rst");
        s_ar_valid = 2'b10;
        s_r_ready  = 2'b11;
        #1;
        check("rst_pre_data", mst_r_ready, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async", {s_ar_ready, s_r_valid, mst_ar_valid, mst_r_ready}, 6'b0);
        r_q.delete();
        ar_q.delete();
        s_ar_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        tick();
        mst_r_valid = 1'b1;
        mst_r_last  = 1'b1;
        mst_r_data  = 32'hBAD0_BAD0;
        #1;
        check("rst_stray_r", {s_r_valid, mst_r_ready}, 3'b000);
        tick();
        mst_r_valid = 1'b0;
        mst_r_last  = 1'b0;
        request(2'b01, 2'b01, 32'h8000_0200, 32'h0, 3'd2, 3'd0, 32'h0000_0066, 2'b00, "postrst");
        serve_ar(0, "postrst");
        serve_r(0, 32'h0000_0066, 2'b00, 0, 1, "postrst");

        repeat (2) tick();
        check("ar_q_drained", ar_q.size(), 0);
        check("r_q_drained", r_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
